// File: rtl/logs_r_sweep.sv
// Sweeps the logistic-map parameter r between R_START and R_END, advancing once per R_INC map iterations.
// Define LOGS_SWEEP_PINGPONG_EN to descend back to R_START after HOLD instead of restarting from R_START.
module logs_r_sweep #(
  parameter int FRAC       = 8,
  parameter int R_INC      = 1000,
  parameter int R_START    = 'h110,
  parameter int R_END      = 'h3FC,
  parameter int R_KNEE     = 'h300,
  parameter int STEP_LO    = 4,
  parameter int STEP_HI    = 1,
  parameter int HOLD_ITERS = 4000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            iter_done,
  output logic [FRAC+1:0] r,
  output logic            r_changed,
  output logic [1:0]      phase
);

  localparam int W  = FRAC + 2;
  localparam int W1 = W + 1;
  localparam int CW = (R_INC > 1) ? $clog2(R_INC) : 1;
  localparam int HW = (HOLD_ITERS > 1) ? $clog2(HOLD_ITERS) : 1;

  localparam logic [W-1:0]  R_START_V = W'(R_START);
  localparam logic [W-1:0]  R_END_V   = W'(R_END);
  localparam logic [W-1:0]  R_KNEE_V  = W'(R_KNEE);
  localparam logic [W1-1:0] R_END_X   = W1'(R_END);
  localparam logic [W1-1:0] STEP_LO_X = W1'(STEP_LO);
  localparam logic [W1-1:0] STEP_HI_X = W1'(STEP_HI);
  localparam logic [CW-1:0] CNT_LAST  = CW'(R_INC - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_ITERS - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    HOLD      = 2'd2,
    RAMP_DOWN = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [HW-1:0]  hold_q, hold_d;
  logic [W-1:0]   r_q, r_d;
  logic           r_changed_q, r_changed_d;

  logic [W1-1:0]  up_sum;
  logic [W-1:0]   up_next;

  // One extra bit so r+step near the top of the range cannot wrap before the clamp.
  always_comb begin
    up_sum  = {1'b0, r_q} + ((r_q < R_KNEE_V) ? STEP_LO_X : STEP_HI_X);
    up_next = (up_sum >= R_END_X) ? R_END_V : up_sum[W-1:0];
  end

`ifdef LOGS_SWEEP_PINGPONG_EN
  localparam logic [W1-1:0] R_START_X = W1'(R_START);
  logic [W1-1:0]  down_step;
  logic [W1-1:0]  down_diff;
  logic [W-1:0]   down_next;

  always_comb begin
    down_step = (r_q > R_KNEE_V) ? STEP_HI_X : STEP_LO_X;
    down_diff = {1'b0, r_q} - down_step;
    down_next = ({1'b0, r_q} < (R_START_X + down_step)) ? R_START_V : down_diff[W-1:0];
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    r_d     = r_q;
    if (enable) begin
      case (state_q)
        IDLE: begin
          state_d = RAMP_UP;
          cnt_d   = '0;
        end
        RAMP_UP: begin
          if (iter_done) begin
            if (cnt_q == CNT_LAST) begin
              cnt_d = '0;
              r_d   = up_next;
              if (up_next == R_END_V) begin
                state_d = HOLD;
                hold_d  = '0;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (iter_done) begin
            if (hold_q == HOLD_LAST) begin
              hold_d = '0;
              cnt_d  = '0;
`ifdef LOGS_SWEEP_PINGPONG_EN
              state_d = RAMP_DOWN;
`else
              state_d = RAMP_UP;
              r_d     = R_START_V;
`endif
            end else begin
              hold_d = hold_q + 1'b1;
            end
          end
        end
`ifdef LOGS_SWEEP_PINGPONG_EN
        RAMP_DOWN: begin
          if (iter_done) begin
            if (cnt_q == CNT_LAST) begin
              cnt_d = '0;
              r_d   = down_next;
              if (down_next == R_START_V) begin
                state_d = RAMP_UP;
              end
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
`endif
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          hold_d  = '0;
        end
      endcase
    end
    r_changed_d = (r_d != r_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      hold_q      <= '0;
      r_q         <= R_START_V;
      r_changed_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      r_q         <= r_d;
      r_changed_q <= r_changed_d;
    end
  end

  assign r         = r_q;
  assign r_changed = r_changed_q;
  assign phase     = state_q;

endmodule

// File: tb/tb_logs_r_sweep.sv
// Directed bench for logs_r_sweep with small sweep parameters; a second instance uses STEP_HI=3.
module tb_logs_r_sweep;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       iter_done;
  logic [9:0] r, r3;
  logic       r_changed, r_changed3;
  logic [1:0] phase, phase3;

  int checks;
  int errors;

  logs_r_sweep #(
    .FRAC(8), .R_INC(4), .R_START('h110), .R_END('h120), .R_KNEE('h118),
    .STEP_LO(4), .STEP_HI(1), .HOLD_ITERS(3)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .iter_done(iter_done),
    .r(r), .r_changed(r_changed), .phase(phase)
  );

  logs_r_sweep #(
    .FRAC(8), .R_INC(4), .R_START('h110), .R_END('h120), .R_KNEE('h118),
    .STEP_LO(4), .STEP_HI(3), .HOLD_ITERS(3)
  ) dut3 (
    .clk(clk), .reset(reset), .enable(enable), .iter_done(iter_done),
    .r(r3), .r_changed(r_changed3), .phase(phase3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 'h%0h", tag, got);
    end
  endtask

  // iter_done held high for n consecutive cycles; returns on the negedge after the last counted edge.
  task automatic pulses(input int n);
    @(negedge clk);
    iter_done = 1'b1;
    repeat (n) @(negedge clk);
    iter_done = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    enable    = 1'b0;
    iter_done = 1'b0;

    #7;
    chk("reset_r", r, 'h110);
    chk("reset_phase", phase, 0);
    chk("reset_rchg", r_changed, 0);

    // First enabled cycle leaves IDLE; its iter_done must not count.
    @(negedge clk);
    reset     = 1'b0;
    enable    = 1'b1;
    iter_done = 1'b1;
    @(negedge clk);
    iter_done = 1'b0;
    chk("idle_exit_phase", phase, 1);
    chk("idle_exit_r", r, 'h110);

    pulses(3);
    chk("three_pulses_r", r, 'h110);
    chk("three_pulses_rchg", r_changed, 0);
    pulses(1);
    chk("first_update_r", r, 'h114);
    chk("first_update_rchg", r_changed, 1);
    @(negedge clk);
    chk("rchg_one_cycle", r_changed, 0);

    pulses(4);
    chk("second_update_r", r, 'h118);
    chk("second_update_phase", phase, 1);
    chk("hi3_at_knee_r", r3, 'h118);

    for (int k = 1; k <= 8; k++) begin
      pulses(4);
      chk($sformatf("fine_r_%0d", k), r, 'h118 + k);
      chk($sformatf("fine_rchg_%0d", k), r_changed, 1);
      chk($sformatf("fine_phase_%0d", k), phase, (k == 8) ? 2 : 1);
      if (k <= 3) begin
        chk($sformatf("hi3_r_%0d", k), r3, (k == 1) ? 'h11B : (k == 2) ? 'h11E : 'h120);
        chk($sformatf("hi3_phase_%0d", k), phase3, (k == 3) ? 2 : 1);
      end
    end

    pulses(2);
    chk("hold_r", r, 'h120);
    chk("hold_phase", phase, 2);
    chk("hold_rchg", r_changed, 0);
    pulses(1);
`ifdef LOGS_SWEEP_PINGPONG_EN
    chk("hold_exit_phase", phase, 3);
    chk("hold_exit_r", r, 'h120);
    chk("hold_exit_rchg", r_changed, 0);
    for (int k = 1; k <= 10; k++) begin
      pulses(4);
      chk($sformatf("down_r_%0d", k), r,
          (k <= 8) ? ('h120 - k) : (k == 9) ? 'h114 : 'h110);
      chk($sformatf("down_phase_%0d", k), phase, (k == 10) ? 1 : 3);
    end
`else
    chk("hold_exit_r", r, 'h110);
    chk("hold_exit_phase", phase, 1);
    chk("hold_exit_rchg", r_changed, 1);
`endif

    // Freeze with iter_done toggling, then resume with the count preserved.
    pulses(2);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      iter_done = ~iter_done;
    end
    @(negedge clk);
    iter_done = 1'b0;
    chk("frozen_r", r, 'h110);
    chk("frozen_phase", phase, 1);
    chk("frozen_rchg", r_changed, 0);
    enable = 1'b1;
    pulses(1);
    chk("resume_one_r", r, 'h110);
    pulses(1);
    chk("resume_two_r", r, 'h114);
    chk("resume_two_rchg", r_changed, 1);

    // Climb back into HOLD, then reset between clock edges.
    pulses(36);
    chk("rehold_r", r, 'h120);
    chk("rehold_phase", phase, 2);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_r", r, 'h110);
    chk("async_reset_phase", phase, 0);
    chk("async_reset_rchg", r_changed, 0);

    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", phase, 1);
    pulses(3);
    chk("post_reset_three_r", r, 'h110);
    pulses(1);
    chk("post_reset_update_r", r, 'h114);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/logs_r_sweep.md
LOGS_R_SWEEP -- requirements
Module: logs_r_sweep

Interface
REQ-001 Parameter FRAC, default 8: fractional bits of r (2.FRAC unsigned fixed-point).
REQ-002 Parameter R_INC, default 1000: iter_done pulses per r update.
REQ-003 Parameter R_START, default 'h110 (1.0625): reset/restart value of r.
REQ-004 Parameter R_END, default 'h3FC (3.984): maximum r; constraint R_START < R_END < 4<<FRAC.
REQ-005 Parameter R_KNEE, default 'h300 (3.0): boundary between coarse and fine steps.
REQ-006 Parameter STEP_LO, default 4: step while r < R_KNEE.
REQ-007 Parameter STEP_HI, default 1: step while r >= R_KNEE.
REQ-008 Parameter HOLD_ITERS, default 4000: iter_done pulses spent at R_END.
REQ-009 clk  input  1  clock; all state on rising edge.
REQ-010 reset  input  1  asynchronous, active-high reset.
REQ-011 enable  input  1  sweep runs while high; freezes while low.
REQ-012 iter_done  input  1  single-cycle pulse, one per new x from the map iterator.
REQ-013 r  output  FRAC+2  current r, registered, to the map iterator.
REQ-014 r_changed  output  1  high exactly one cycle after each r update.
REQ-015 phase  output  2  current FSM state code.

Function
REQ-016 FSM states: IDLE=0, RAMP_UP=1, HOLD=2, RAMP_DOWN=3; phase equals the state code.
REQ-017 IDLE -> RAMP_UP on first cycle with enable=1; iter_done in that cycle is not counted.
REQ-018 Iteration counter (clog2(R_INC) bits) counts iter_done in RAMP_UP/RAMP_DOWN; when iter_done=1 and count=R_INC-1: count:=0 and r updates on that edge.
REQ-019 RAMP_UP update: step = STEP_LO if r < R_KNEE else STEP_HI; r := min(r+step, R_END), computed one bit wider to avoid overflow.
REQ-020 RAMP_UP -> HOLD on the edge where r becomes R_END; counter cleared.
REQ-021 HOLD counts iter_done; on the HOLD_ITERS-th pulse leaves HOLD per REQ-031/032; r unchanged during HOLD.
REQ-022 RAMP_DOWN update: step = STEP_HI if r > R_KNEE else STEP_LO; r := max(r-step, R_START); reaching R_START -> RAMP_UP, counter cleared.
REQ-023 r_changed asserts the cycle after any edge where r takes a different value, including wrap, and never otherwise.
REQ-024 enable=0: state, counters and r hold; iter_done ignored; r_changed low after any pending pulse completes.
REQ-025 enable deasserted mid-ramp and reasserted resumes with the counter value preserved; no return to IDLE.
REQ-026 iter_done asserted continuously is counted once per cycle.

Reset
REQ-027 Asynchronous assertion: state=IDLE, r=R_START, r_changed=0, phase=0, all counters 0.
REQ-028 Reset mid-ramp or mid-HOLD discards progress; deassertion is synchronous to clk, first update occurs R_INC counted pulses after leaving IDLE.
REQ-029 No output is X after reset; no reset-less state.

Configuration
REQ-030 Macro LOGS_SWEEP_PINGPONG_EN selects HOLD exit behaviour.
REQ-031 Without LOGS_SWEEP_PINGPONG_EN: HOLD exit sets r := R_START, state RAMP_UP, r_changed pulses; RAMP_DOWN is unreachable and may be omitted.
REQ-032 With LOGS_SWEEP_PINGPONG_EN: HOLD exit enters RAMP_DOWN, r unchanged; sweep descends per REQ-022.

Verification (R_INC=4, HOLD_ITERS=3, R_START='h110, R_END='h120, R_KNEE='h118, STEP_LO=4, STEP_HI=1 unless noted)
REQ-033 Reset, enable=1, 4 iter_done pulses -> r 'h110 -> 'h114, r_changed one cycle; next 4 -> 'h118; phase=1.
REQ-034 Continue at 4 pulses per update -> r 'h119...'h120 (8 updates) then phase=2; 3 more pulses -> r='h110, phase=1 (macro off).
REQ-035 STEP_HI=3, from 'h118 -> 'h11B, 'h11E, then clamp 'h120 and phase=2.
REQ-036 Macro on: after HOLD -> phase=3, r steps 'h11F...'h118 by 1, then 'h114, 'h110 -> phase=1.
REQ-037 enable low for 10 cycles after 2 counted pulses with iter_done toggling -> r frozen; after re-enable, 2 more pulses update r.
REQ-038 reset asserted mid-HOLD, asynchronous to clk -> r='h110, phase=0, r_changed=0 immediately.
